// File: rtl/swipt_duty_demod_if.sv
// Signal bundle between the rectifier/comparator front end, the packet logic
// and the SWIPT duty-cycle demodulator.
interface swipt_duty_demod_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             pwm_in;
  logic             data_out;
  logic             data_valid;
  logic             mod_active;
  logic             carrier_ok;
  logic [CNT_W-1:0] duty_hi;
  logic [CNT_W-1:0] duty_per;
  logic [CNT_W-1:0] base_hi;
  logic [CNT_W-1:0] base_per;

  modport master (
    output enable, pwm_in,
    input  data_out, data_valid, mod_active, carrier_ok,
    input  duty_hi, duty_per, base_hi, base_per
  );

  modport slave (
    input  enable, pwm_in,
    output data_out, data_valid, mod_active, carrier_ok,
    output duty_hi, duty_per, base_hi, base_per
  );
endinterface

// File: rtl/swipt_duty_demod.sv
// Duty-cycle demodulator: measures received PWM high-time/period, learns the
// nominal duty during acquisition, then decodes bits by ratio against it.
module swipt_duty_demod #(
  parameter int CNT_W     = 16,
  parameter int ACQ_N     = 4,
  parameter int MIN_RUN   = 2,
  parameter int STUCK_CYC = 1024,
  parameter int LOSS_N    = 16
) (
  input logic              clk,
  input logic              rst,
  swipt_duty_demod_if.slave bus
);
  localparam int PW   = 2*CNT_W + 3;
  localparam int ALOG = $clog2(ACQ_N);
  localparam int SW   = CNT_W + ALOG;
  localparam int AW   = $clog2(ACQ_N + 1);
  localparam int RW   = $clog2(MIN_RUN + 1);
  localparam int LW   = $clog2(LOSS_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] STUCK   = CNT_W'(STUCK_CYC);

  typedef enum logic {ACQ, TRACK} state_t;
  typedef enum logic [1:0] {NOM, HIGH, LOW} cls_t;

  state_t state, state_next;
  cls_t   cls_q, cls_new;

  logic             clr, rise, first_seen, lose, acq_done, fire;
  logic             s_meta, s, s_d;
  logic [CNT_W-1:0] per_cnt, hi_cnt, duty_hi, duty_per, base_hi, base_per;
  logic             meas_stb, meas_syn;
  logic [PW-1:0]    lhs, rhs_hi, rhs_lo;
  logic             p_stb, p_syn_lo;
  logic [SW-1:0]    sum_hi, sum_per, sum_hi_next, sum_per_next;
  logic [AW-1:0]    acq_cnt;
  logic [RW-1:0]    run, run_next;
  logic [LW-1:0]    loss_cnt;
  logic             dout, dvalid, cok;

  assign clr  = rst | ~bus.enable;
  assign rise = s & ~s_d;

  // Synchronizer, period/high counters and measurement latch
  always_ff @(posedge clk) begin
    if (clr) begin
      s_meta <= 1'b0; s <= 1'b0; s_d <= 1'b0;
      per_cnt <= '0; hi_cnt <= '0; duty_hi <= '0; duty_per <= '0;
      meas_stb <= 1'b0; meas_syn <= 1'b0; first_seen <= 1'b0;
    end else begin
      s_meta   <= bus.pwm_in;
      s        <= s_meta;
      s_d      <= s;
      meas_stb <= 1'b0;
      meas_syn <= 1'b0;
      if (rise) begin
        per_cnt    <= CNT_W'(1);
        hi_cnt     <= CNT_W'(1);
        first_seen <= 1'b1;
        if (first_seen && !lose) begin
          duty_hi  <= hi_cnt;
          duty_per <= per_cnt;
          meas_stb <= 1'b1;
        end
      end else if (per_cnt == STUCK) begin
        duty_per <= STUCK;
        duty_hi  <= s ? STUCK : '0;
        meas_stb <= 1'b1;
        meas_syn <= 1'b1;
        per_cnt  <= '0;
        hi_cnt   <= '0;
      end else begin
        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
        if (s && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_W'(1);
      end
      if (lose) first_seen <= 1'b0;
    end
  end

  // Cross-multiplied ratio terms; only measurements taken while tracking enter
  always_ff @(posedge clk) begin
    if (clr) begin
      lhs <= '0; rhs_hi <= '0; rhs_lo <= '0;
      p_stb <= 1'b0; p_syn_lo <= 1'b0;
    end else begin
      p_stb    <= meas_stb && (state == TRACK);
      p_syn_lo <= meas_syn && (duty_hi == '0);
      lhs      <= (PW'(duty_hi) * PW'(base_per)) << 2;
      rhs_hi   <= PW'(base_hi) * PW'(duty_per) * PW'(5);
      rhs_lo   <= PW'(base_hi) * PW'(duty_per) * PW'(3);
    end
  end

  always_comb begin
    cls_new = NOM;
    if (lhs > rhs_hi)      cls_new = HIGH;
    else if (lhs < rhs_lo) cls_new = LOW;
  end

  always_comb begin
    run_next = RW'(1);
    if (cls_new == cls_q)
      run_next = (run == RW'(MIN_RUN)) ? run : run + RW'(1);
  end

  assign fire = (run_next == RW'(MIN_RUN)) && ((cls_new != cls_q) || (run != RW'(MIN_RUN)));
  assign sum_hi_next  = sum_hi + SW'(duty_hi);
  assign sum_per_next = sum_per + SW'(duty_per);
  assign acq_done = (state == ACQ) && meas_stb && !meas_syn && (acq_cnt == AW'(ACQ_N - 1));
  assign lose     = (state == TRACK) && p_stb && p_syn_lo && (loss_cnt == LW'(LOSS_N - 1));

  always_ff @(posedge clk) begin
    if (clr) state <= ACQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACQ:     if (acq_done) state_next = TRACK;
      TRACK:   if (lose)     state_next = ACQ;
      default: state_next = ACQ;
    endcase
  end

  // Baseline learning, run tracking and bit decisions.
  // Stuck-low periods are loss evidence only and leave the run untouched.
  always_ff @(posedge clk) begin
    if (clr) begin
      sum_hi <= '0; sum_per <= '0; acq_cnt <= '0;
      base_hi <= '0; base_per <= '0; cok <= 1'b0;
      cls_q <= NOM; run <= '0; loss_cnt <= '0;
      dout <= 1'b0; dvalid <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      if (state == ACQ && meas_stb) begin
        if (meas_syn || acq_done) begin
          sum_hi <= '0; sum_per <= '0; acq_cnt <= '0;
        end else begin
          sum_hi <= sum_hi_next; sum_per <= sum_per_next; acq_cnt <= acq_cnt + AW'(1);
        end
        if (acq_done) begin
          base_hi  <= sum_hi_next[SW-1:ALOG];
          base_per <= sum_per_next[SW-1:ALOG];
          cok      <= 1'b1;
        end
      end
      if (state == TRACK && p_stb) begin
        if (p_syn_lo) begin
          if (lose) begin
            cok <= 1'b0; cls_q <= NOM; run <= '0; loss_cnt <= '0;
          end else begin
            loss_cnt <= loss_cnt + LW'(1);
          end
        end else begin
          loss_cnt <= '0;
          cls_q    <= cls_new;
          run      <= run_next;
          if (fire && cls_new != NOM) begin
            dout   <= (cls_new == LOW);
            dvalid <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.data_out   = dout;
  assign bus.data_valid = dvalid;
  assign bus.mod_active = (cls_q != NOM);
  assign bus.carrier_ok = cok;
  assign bus.duty_hi    = duty_hi;
  assign bus.duty_per   = duty_per;
  assign bus.base_hi    = base_hi;
  assign bus.base_per   = base_per;
endmodule

// File: tb/tb_swipt_duty_demod.sv
// Directed bench for swipt_duty_demod: acquisition, HIGH/LOW/NOM decoding,
// carrier loss, stuck-high decoding and enable-driven reset.
module tb_swipt_duty_demod;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   assertCount = 0;
  int   failCount = 0;
  int   dvCount = 0;

  swipt_duty_demod_if #(.CNT_W(16)) bus ();

  swipt_duty_demod dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every data_valid cycle is counted, so a stretched pulse shows up as extra
  always @(posedge clk) begin
    #1;
    if (bus.data_valid === 1'b1) dvCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int hi, input int per, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        bus.pwm_in = (c < hi);
      end
  endtask

  task automatic holdLevel(input logic level, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.pwm_in = level;
    end
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_data_out",   32'(bus.data_out),   0);
    checkOutput("rst_data_valid", 32'(bus.data_valid), 0);
    checkOutput("rst_carrier_ok", 32'(bus.carrier_ok), 0);
    checkOutput("rst_duty_hi",    32'(bus.duty_hi),    0);
    checkOutput("rst_base_per",   32'(bus.base_per),   0);
    @(negedge clk);
    rst = 1'b0;
    holdLevel(1'b0, 5);

    $display("[TB] acquisition at 40/100");
    applyStimulus(40, 100, 6);
    checkOutput("acq_base_hi",    32'(bus.base_hi),    40);
    checkOutput("acq_base_per",   32'(bus.base_per),   100);
    checkOutput("acq_carrier_ok", 32'(bus.carrier_ok), 1);
    checkOutput("acq_no_valid",   32'(dvCount),        0);
    checkOutput("acq_mod_active", 32'(bus.mod_active), 0);

    $display("[TB] HIGH class 60/100");
    applyStimulus(60, 100, 3);
    checkOutput("hi_valid_count", 32'(dvCount),        1);
    checkOutput("hi_data_out",    32'(bus.data_out),   0);
    checkOutput("hi_mod_active",  32'(bus.mod_active), 1);
    checkOutput("hi_duty_hi",     32'(bus.duty_hi),    60);

    $display("[TB] LOW class 13/100 then NOM 45/100");
    applyStimulus(13, 100, 3);
    checkOutput("lo_valid_count", 32'(dvCount),        2);
    checkOutput("lo_data_out",    32'(bus.data_out),   1);
    checkOutput("lo_mod_active",  32'(bus.mod_active), 1);
    applyStimulus(45, 100, 2);
    checkOutput("nom_valid_count", 32'(dvCount),        2);
    checkOutput("nom_mod_active",  32'(bus.mod_active), 0);
    checkOutput("nom_duty_hi",     32'(bus.duty_hi),    45);
    checkOutput("nom_duty_per",    32'(bus.duty_per),   100);

    $display("[TB] carrier loss by holding low");
    holdLevel(1'b0, 15700);
    checkOutput("loss15_carrier_ok", 32'(bus.carrier_ok), 1);
    holdLevel(1'b0, 1300);
    checkOutput("loss_carrier_ok",  32'(bus.carrier_ok), 0);
    checkOutput("loss_data_out",    32'(bus.data_out),   1);
    checkOutput("loss_mod_active",  32'(bus.mod_active), 0);
    checkOutput("loss_valid_count", 32'(dvCount),        2);
    applyStimulus(40, 100, 5);
    checkOutput("reacq_carrier_ok", 32'(bus.carrier_ok), 1);
    checkOutput("reacq_base_hi",    32'(bus.base_hi),    40);

    $display("[TB] stuck-high is HIGH evidence");
    holdLevel(1'b1, 3000);
    checkOutput("stk_valid_count", 32'(dvCount),        3);
    checkOutput("stk_data_out",    32'(bus.data_out),   0);
    checkOutput("stk_carrier_ok",  32'(bus.carrier_ok), 1);
    checkOutput("stk_duty_hi",     32'(bus.duty_hi),    1024);
    checkOutput("stk_duty_per",    32'(bus.duty_per),   1024);
    holdLevel(1'b0, 50);

    $display("[TB] enable drop during LOW run");
    applyStimulus(13, 100, 3);
    checkOutput("lo2_valid_count", 32'(dvCount),        4);
    checkOutput("lo2_data_out",    32'(bus.data_out),   1);
    applyStimulus(13, 100, 1);
    checkOutput("lo2_mod_active",  32'(bus.mod_active), 1);
    @(negedge clk);
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("dis_data_out",   32'(bus.data_out),   0);
    checkOutput("dis_mod_active", 32'(bus.mod_active), 0);
    checkOutput("dis_carrier_ok", 32'(bus.carrier_ok), 0);
    checkOutput("dis_duty_hi",    32'(bus.duty_hi),    0);
    checkOutput("dis_duty_per",   32'(bus.duty_per),   0);
    checkOutput("dis_base_hi",    32'(bus.base_hi),    0);
    checkOutput("dis_base_per",   32'(bus.base_per),   0);
    applyStimulus(13, 100, 2);
    checkOutput("dis_valid_count", 32'(dvCount),        4);
    checkOutput("dis_hold_ok",     32'(bus.carrier_ok), 0);

    bus.enable = 1'b1;
    applyStimulus(40, 100, 2);
    checkOutput("reen_partial_ok", 32'(bus.carrier_ok), 0);
    applyStimulus(40, 100, 4);
    checkOutput("reen_carrier_ok", 32'(bus.carrier_ok), 1);
    checkOutput("reen_base_per",   32'(bus.base_per),   100);
    checkOutput("reen_valid_count", 32'(dvCount),       4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/swipt_duty_demod.md
Name: swipt_duty_demod

Overview:
Receiver-side demodulator for the SWIPT duty-cycle data link. The transmitter stretches the PWM duty above nominal to send a 0 and shrinks it below nominal (down to 0 %) to send a 1. This block measures high-time and period of the received PWM, learns the nominal duty during acquisition, and recovers the bit stream by ratio comparison against that baseline. It sits between the rectifier/comparator digital input and the packet/command logic.

Parameters:
CNT_W, 16, width of high/period counters and measurement outputs
ACQ_N, 4, periods averaged to learn baseline (power of 2; only 4 is required)
MIN_RUN, 2, consecutive same-class periods needed to accept a bit
STUCK_CYC, 1024, cycles without a rising edge before a synthetic period is emitted
LOSS_N, 16, consecutive stuck-low synthetic periods before carrier loss

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  link alive; low acts like reset except parameters
pwm_in  in  1  asynchronous received PWM
data_out  out  1  last decoded bit (level)
data_valid  out  1  one-cycle pulse when data_out is (re)loaded
mod_active  out  1  high while current class is HIGH or LOW
carrier_ok  out  1  baseline learned and carrier present
duty_hi  out  CNT_W  last measured high-time (cycles)
duty_per  out  CNT_W  last measured period (cycles)
base_hi  out  CNT_W  learned baseline high-time
base_per  out  CNT_W  learned baseline period

Behaviour:
- Reset (rst=1 or enable=0, sampled on clk): all outputs 0, counters 0, synchronizer 0, state ACQ, first-edge flag cleared.
- Input: 2-flop synchronizer on pwm_in; edge detect on synchronized value s. All counting uses s.
- Counters: per_cnt +1 every cycle, hi_cnt +1 when s=1; both saturate at all-ones.
- Rising edge of s: latch duty_hi=hi_cnt, duty_per=per_cnt, pulse meas_stb; counters restart at 1 (hi_cnt=1). First rising edge after reset/loss only restarts counters, no meas_stb.
- Stuck: per_cnt reaching STUCK_CYC with no edge -> synthetic measurement duty_per=STUCK_CYC, duty_hi=STUCK_CYC if s=1 else 0, meas_stb, counters restart at 0. Rising edge and stuck in same cycle: rising edge wins.
- Classifier (registered, class valid 2 cycles after meas_stb): P=duty_hi*base_per, Q=duty_hi... use full 2*CNT_W+3 products: HIGH if 4*duty_hi*base_per > 5*base_hi*duty_per; LOW if 4*duty_hi*base_per < 3*base_hi*duty_per; else NOM.
- FSM ACQ: sum ACQ_N measurements of hi and per (width CNT_W+2); after ACQ_N-th, base_hi=sum_hi>>2, base_per=sum_per>>2, carrier_ok=1, go TRACK. Synthetic measurements in ACQ restart the sum (count=0).
- FSM TRACK: run counter per class; same class as previous -> run+1 (saturate at MIN_RUN), else run=1. When run first reaches MIN_RUN: HIGH -> data_out=0, data_valid=1; LOW -> data_out=1, data_valid=1; NOM -> no pulse. mod_active = (latched class != NOM). Exactly one data_valid per run, even if the run lasts indefinitely.
- Loss: LOSS_N consecutive synthetic stuck-low measurements in TRACK -> carrier_ok=0, mod_active=0, state ACQ, first-edge flag cleared; data_out holds value. Stuck-high measurements are HIGH-class evidence, never loss.
- Baseline does not update in TRACK. base_hi=0 in TRACK is impossible by construction (ACQ rejects synthetic).

Test Plan:
- Reset then PWM period 100, high 40, for 6 periods -> after 5th rising edge base_hi=40, base_per=100, carrier_ok=1, data_valid never pulsed.
- From baseline 40/100, send high 60/100 for 3 periods -> data_valid single pulse 2 cycles after 2nd such meas_stb, data_out=0, mod_active=1.
- High 13/100 for 2 periods -> data_out=1, one data_valid; then 45/100 -> class NOM, mod_active=0, no pulse.
- Hold pwm_in low 16*1024+ cycles in TRACK -> carrier_ok=0 after 16th stuck measurement, state ACQ; data_out unchanged; resumed 40/100 reacquires after 5 rising edges.
- Hold pwm_in high 3000 cycles in TRACK -> two synthetic HIGH measurements -> data_out=0, data_valid once, carrier_ok stays 1.
- Assert enable=0 mid-run of LOW periods -> next clk all outputs 0, no data_valid; re-enable requires fresh acquisition.
